alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters, such as the integer pipe and the address-generation pipe.
- Arbitrates round-robin and drives the ALU operand and control inputs.
- Captures alu_data into a one-entry output register, which is drained with a valid/ready handshake.
- Sits between issue logic and writeback. It is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_share_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUCtrl encodings and legality check shared by ALU-side units.
// alu_ctrl_legal() is used only when ALU_ARB_ILLEGAL_CHK_EN is defined.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS: alu_ctrl_legal = 1'b1;
      default:                                     alu_ctrl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, ALU and response signals of the shared-ALU arbiter.
// rsp_err exists only when ALU_ARB_ILLEGAL_CHK_EN is defined.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_rs1;
  logic [NUM_REQ*32-1:0]    req_rs2;
  logic [NUM_REQ*4-1:0]     req_ctrl;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [31:0]              alu_rs1;
  logic [31:0]              alu_rs2;
  logic [3:0]               alu_ctrl;
  logic [31:0]              alu_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic                     rsp_err;
`endif

  // master: issue side, writeback side and the ALU itself
  modport master (
    output req_valid, req_rs1, req_rs2, req_ctrl, req_tag, alu_data, rsp_ready,
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    input  rsp_err,
`endif
    input  req_ready, alu_rs1, alu_rs2, alu_ctrl, rsp_valid, rsp_data, rsp_id, rsp_tag
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_ctrl, req_tag, alu_data, rsp_ready,
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    output rsp_err,
`endif
    output req_ready, alu_rs1, alu_rs2, alu_ctrl, rsp_valid, rsp_data, rsp_id, rsp_tag
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant searched upward from i_ptr.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    if (i_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!w_found && i_req[i] && (i == (int'(i_ptr) + k) % NUM_REQ)) begin
            o_grant[i] = 1'b1;
            w_found    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU with a one-entry response register.
// ALU_ARB_ILLEGAL_CHK_EN adds rsp_err and zeroes results of illegal ALUCtrl codes.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5,
  parameter int ID_W    = 2
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [31:0]        r_data;
  logic [ID_W-1:0]    r_id;
  logic [TAG_W-1:0]   r_tag;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_can_accept;
  logic               w_accept;
  logic [31:0]        w_rs1;
  logic [31:0]        w_rs2;
  logic [3:0]         w_ctrl;
  logic [TAG_W-1:0]   w_tag;
  logic [ID_W-1:0]    w_id;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [31:0]        w_cap_data;

  // Grant is suppressed while reset is held so req_ready is 0 without waiting for a clock
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (rst),
    .o_grant (w_grant)
  );

  assign w_can_accept = (r_state == ST_EMPTY) || bus.rsp_ready;
  assign w_ready      = w_grant & {NUM_REQ{w_can_accept}};
  assign w_accept     = |w_ready;

  // Unselected requesters leave the ALU inputs at ADD 0+0
  always_comb begin
    w_rs1      = '0;
    w_rs2      = '0;
    w_ctrl     = ALU_ADD;
    w_tag      = '0;
    w_id       = '0;
    w_next_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_rs1      = bus.req_rs1[32*i +: 32];
        w_rs2      = bus.req_rs2[32*i +: 32];
        w_ctrl     = bus.req_ctrl[4*i +: 4];
        w_tag      = bus.req_tag[TAG_W*i +: TAG_W];
        w_id       = ID_W'(i);
        w_next_ptr = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic w_legal;
  logic r_err;
  assign w_legal    = alu_ctrl_legal(w_ctrl);
  assign w_cap_data = w_legal ? bus.alu_data : 32'd0;
  assign bus.rsp_err = r_err;
`else
  assign w_cap_data = bus.alu_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_tag   <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_data <= w_cap_data;
        r_id   <= w_id;
        r_tag  <= w_tag;
        r_ptr  <= w_next_ptr;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        r_err  <= !w_legal;
`endif
      end
      // A drain coinciding with an accept keeps the register FULL with no bubble
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_FULL;
        ST_FULL:  if (!w_accept && bus.rsp_ready) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.alu_rs1   = w_rs1;
  assign bus.alu_rs2   = w_rs2;
  assign bus.alu_ctrl  = w_ctrl;
  assign bus.rsp_valid = (r_state == ST_FULL);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_tag   = r_tag;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed bench for alu_share_arbiter with a behavioural ALU model.
// The rsp_err section is built only when ALU_ARB_ILLEGAL_CHK_EN is defined.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_share_arbiter_if #(.NUM_REQ(2), .TAG_W(5), .ID_W(2)) bus ();

  alu_share_arbiter #(.NUM_REQ(2), .TAG_W(5), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal codes yield a junk pattern so the arbiter's zeroing is visible
  always_comb begin
    case (bus.alu_ctrl)
      ALU_ADD:  bus.alu_data = bus.alu_rs1 + bus.alu_rs2;
      ALU_SUB:  bus.alu_data = bus.alu_rs1 - bus.alu_rs2;
      ALU_SLL:  bus.alu_data = bus.alu_rs1 << bus.alu_rs2[4:0];
      ALU_SLT:  bus.alu_data = {31'd0, $signed(bus.alu_rs1) < $signed(bus.alu_rs2)};
      ALU_SLTU: bus.alu_data = {31'd0, bus.alu_rs1 < bus.alu_rs2};
      ALU_XOR:  bus.alu_data = bus.alu_rs1 ^ bus.alu_rs2;
      ALU_SRL:  bus.alu_data = bus.alu_rs1 >> bus.alu_rs2[4:0];
      ALU_SRA:  bus.alu_data = $unsigned($signed(bus.alu_rs1) >>> bus.alu_rs2[4:0]);
      ALU_OR:   bus.alu_data = bus.alu_rs1 | bus.alu_rs2;
      ALU_AND:  bus.alu_data = bus.alu_rs1 & bus.alu_rs2;
      ALU_PASS: bus.alu_data = bus.alu_rs2;
      default:  bus.alu_data = 32'hBAD0_BAD0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] ctrl, input logic [4:0] tag);
    bus.req_rs1[32*i +: 32] = rs1;
    bus.req_rs2[32*i +: 32] = rs2;
    bus.req_ctrl[4*i +: 4]  = ctrl;
    bus.req_tag[5*i +: 5]   = tag;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_ctrl  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset: outputs cleared, a valid request is not accepted
    tick();
    bus.req_valid = 2'b01;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  bus.rsp_data,       32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_rsp_tag",   32'(bus.rsp_tag),   32'd0);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
`endif
    tick();
    rst = 1'b1;

    // Single request: 5+7 tag 3
    set_req(0, 32'd5, 32'd7, ALU_ADD, 5'd3);
    bus.rsp_ready = 1'b1;
    #1;
    check("single_req_ready", 32'(bus.req_ready), 32'b01);
    check("single_alu_rs1",   bus.alu_rs1,        32'd5);
    tick();
    bus.req_valid = '0;
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_rsp_data",  bus.rsp_data,       32'd12);
    check("single_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("single_rsp_tag",   32'(bus.rsp_tag),   32'd3);
    tick();
    check("drain_rsp_valid",  32'(bus.rsp_valid), 32'd0);

    // Both valid; pointer sits at 1 after the single grant to req0
    set_req(0, 32'd10, 32'd3, ALU_SUB, 5'd1);
    set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 5'd2);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      int exp_id;
      exp_id = (c % 2 == 0) ? 1 : 0;
      #1;
      check($sformatf("rr_ready_%0d", c), 32'(bus.req_ready), 32'(1 << exp_id));
      tick();
      check($sformatf("rr_id_%0d", c),   32'(bus.rsp_id),  32'(exp_id));
      check($sformatf("rr_data_%0d", c), bus.rsp_data,     (exp_id == 1) ? 32'd1 : 32'd7);
      check($sformatf("rr_tag_%0d", c),  32'(bus.rsp_tag), (exp_id == 1) ? 32'd2 : 32'd1);
      check($sformatf("rr_valid_%0d", c), 32'(bus.rsp_valid), 32'd1);
    end

    // Backpressure with req1 waiting
    set_req(1, 32'd100, 32'd23, ALU_ADD, 5'd9);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_ready_%0d", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp_data_%0d", c),  bus.rsp_data,       32'd7);
      check($sformatf("bp_valid_%0d", c), 32'(bus.rsp_valid), 32'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'b10);
    tick();
    check("bp_new_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_new_data",  bus.rsp_data,       32'd123);
    check("bp_new_id",    32'(bus.rsp_id),    32'd1);
    check("bp_new_tag",   32'(bus.rsp_tag),   32'd9);

    // Move pointer to 1, stall, then reset asynchronously mid-cycle
    bus.req_valid = 2'b01;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_rsp_data",  bus.rsp_data,       32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_first_grant", 32'(bus.req_ready), 32'b01);
    bus.rsp_ready = 1'b1;
    tick();
    check("arst_rsp_id",   32'(bus.rsp_id), 32'd0);
    check("arst_rsp_data", bus.rsp_data,    32'd7);

    // Idle: ALU inputs forced to ADD 0+0, response register drains
    bus.req_valid = '0;
    tick();
    check("idle_alu_ctrl",  32'(bus.alu_ctrl),  32'd0);
    check("idle_alu_rs1",   bus.alu_rs1,        32'd0);
    check("idle_alu_rs2",   bus.alu_rs2,        32'd0);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("idle_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    check("idle_data_held",  bus.rsp_data,       32'd7);

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    set_req(0, 32'd5, 32'd7, 4'b1001, 5'd4);
    bus.req_valid = 2'b01;
    tick();
    check("illegal_rsp_data", bus.rsp_data,       32'd0);
    check("illegal_rsp_err",  32'(bus.rsp_err),   32'd1);
    check("illegal_rsp_val",  32'(bus.rsp_valid), 32'd1);
    set_req(0, 32'd0, 32'h0000_DEAD, ALU_PASS, 5'd5);
    tick();
    bus.req_valid = '0;
    check("pass_rsp_err",  32'(bus.rsp_err), 32'd0);
    check("pass_rsp_data", bus.rsp_data,     32'h0000_DEAD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
